// File: rtl/wt_inval_queue.sv
// ----------------------------------------------------------------------------
// wt_inval_queue
//   Invalidation request queue placed in front of the write-through cache
//   invalidation port. Snoop addresses are aligned to a cache line, stored in
//   a circular FIFO and presented one at a time with a valid/ready handshake.
//
//   Optional feature macro: WT_INVAL_COALESCE_EN
//     When defined, an incoming line that is already pending is acknowledged
//     but not stored, and coalesced_cnt_o counts such drops (saturating).
//     When undefined, every accepted request is stored and coalesced_cnt_o
//     is tied to zero.
//
// Ports:
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   snoop_addr_i     invalidation address from the interconnect
//   snoop_valid_i    snoop request valid
//   snoop_ready_o    queue can accept a request
//   inval_addr_o     line-aligned head address to the cache subsystem
//   inval_valid_o    head entry valid
//   inval_ready_i    cache subsystem accepts the head entry
//   flush_i          discard all pending entries
//   empty_o          queue empty
//   occupancy_o      number of stored entries
//   coalesced_cnt_o  saturating count of dropped duplicates
// ----------------------------------------------------------------------------
module wt_inval_queue #(
  parameter int Depth           = 4,
  parameter int AddrWidth       = 64,
  parameter int LineOffsetWidth = 4,
  parameter int CntWidth        = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [AddrWidth-1:0]         snoop_addr_i,
  input  logic                         snoop_valid_i,
  output logic                         snoop_ready_o,
  output logic [AddrWidth-1:0]         inval_addr_o,
  output logic                         inval_valid_o,
  input  logic                         inval_ready_i,
  input  logic                         flush_i,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   occupancy_o,
  output logic [CntWidth-1:0]          coalesced_cnt_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [AddrWidth-1:0] LineMask =
    ~((AddrWidth'(1) << LineOffsetWidth) - AddrWidth'(1));

  logic [AddrWidth-1:0] mem_q [Depth];
  logic [AddrWidth-1:0] mem_d [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;

  logic [AddrWidth-1:0] snoop_line_s;
  logic                 deq_s;
  logic                 acc_s;
  logic                 enq_s;
  logic                 match_s;

  assign snoop_line_s  = snoop_addr_i & LineMask;
  // Ready depends only on registered count and flush, never on the inputs
  // of the current handshake, so a full queue refuses even while popping.
  assign snoop_ready_o = (count_q < DepthCnt) && !flush_i;
  assign inval_valid_o = (count_q != {CntW{1'b0}});
  assign empty_o       = (count_q == {CntW{1'b0}});
  assign occupancy_o   = count_q;
  assign inval_addr_o  = mem_q[rd_ptr_q];

  assign deq_s = inval_valid_o && inval_ready_i;
  assign acc_s = snoop_valid_i && snoop_ready_o;
  assign enq_s = acc_s && !match_s;

`ifdef WT_INVAL_COALESCE_EN
  logic [CntWidth-1:0] coal_cnt_q, coal_cnt_d;

  // Slot is live when its distance from the read pointer is below count.
  function automatic logic slot_live(input logic [PtrW-1:0] slot,
                                     input logic [PtrW-1:0] rd,
                                     input logic [CntW-1:0] cnt);
    logic [PtrW-1:0] off;
    off = slot - rd;
    return ({1'b0, off} < cnt);
  endfunction

  // Duplicate detect against live entries, ignoring a head being popped now.
  always_comb begin
    match_s = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (slot_live(PtrW'(i), rd_ptr_q, count_q) &&
          !(deq_s && (PtrW'(i) == rd_ptr_q)) &&
          (mem_q[i] == snoop_line_s)) begin
        match_s = 1'b1;
      end else begin
        match_s = match_s;
      end
    end
  end

  // Saturating counter of acknowledged-but-dropped duplicates.
  always_comb begin
    coal_cnt_d = coal_cnt_q;
    if (acc_s && match_s && (coal_cnt_q != {CntWidth{1'b1}})) begin
      coal_cnt_d = coal_cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
    end else begin
      coal_cnt_d = coal_cnt_q;
    end
  end

  // Coalesce counter register; flush deliberately leaves it untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      coal_cnt_q <= {CntWidth{1'b0}};
    end else begin
      coal_cnt_q <= coal_cnt_d;
    end
  end

  assign coalesced_cnt_o = coal_cnt_q;
`else
  assign match_s         = 1'b0;
  assign coalesced_cnt_o = {CntWidth{1'b0}};
`endif

  // Next-state for storage, pointers and count; flush wins over everything.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {PtrW{1'b0}};
      rd_ptr_d = {PtrW{1'b0}};
      count_d  = {CntW{1'b0}};
    end else begin
      if (enq_s) begin
        mem_d[wr_ptr_q] = snoop_line_s;
        wr_ptr_d        = wr_ptr_q + {{(PtrW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + {{(PtrW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CntW'(enq_s) - CntW'(deq_s);
    end
  end

  // Queue state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= {AddrWidth{1'b0}};
      end
      wr_ptr_q <= {PtrW{1'b0}};
      rd_ptr_q <= {PtrW{1'b0}};
      count_q  <= {CntW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
